// File: rtl/parity_pkg.sv
// parity_pkg: shared types and constants for the parity frame sequencer
package parity_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, REPORT} state_e;
  localparam bit EVEN = 1'b1;
  localparam bit ODD = 1'b0;
  localparam int DEF_DATA_BITS = 3;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/parity_accumulator.sv
// parity_accumulator: one-bit XOR fold of data bits with final parity compare
module parity_accumulator (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  input  logic check,
  input  logic even_mode,
  output logic err
);
  logic acc_q, acc_d;
  // fold accepted data bits; clear at frame start
  always_comb acc_d = clr ? 1'b0 : en ? acc_q ^ bit_in : acc_q;
  // accumulator register
  always_ff @(posedge clk) acc_q <= rst ? 1'b0 : acc_d;
  assign err = check & (acc_q ^ bit_in ^ even_mode ^ 1'b1);
endmodule

// File: rtl/parity_frame_sequencer.sv
// parity_frame_sequencer: serial frame FSM with parity verdict and saturating counters
module parity_frame_sequencer
  import parity_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter bit EVEN_PARITY = EVEN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             parity_err,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_BITS - 1);
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic perr_q, perr_d;
  logic [CNT_W-1:0] fc_q, fc_d, ec_q, ec_d;
  logic take_start, accept, check, err;
  assign take_start = (state_q == IDLE) && start;
  assign accept = (state_q == DATA) && bit_valid;
  assign check = (state_q == PARITY) && bit_valid;
  parity_accumulator u_acc (
    .clk(clk),
    .rst(rst),
    .clr(take_start),
    .en(accept),
    .bit_in(bit_in),
    .check(check),
    .even_mode(EVEN_PARITY),
    .err(err)
  );
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      perr_q <= 1'b0;
      fc_q <= '0;
      ec_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      perr_q <= perr_d;
      fc_q <= fc_d;
      ec_q <= ec_d;
    end
  end
  // next-state: start opens a frame, last data bit moves to parity, parity bit to report
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? DATA : IDLE;
      DATA:    state_d = (accept && idx_q == LAST) ? PARITY : DATA;
      PARITY:  state_d = bit_valid ? REPORT : PARITY;
      default: state_d = IDLE;
    endcase
  end
  // bit index, verdict and saturating counters
  always_comb begin
    idx_d = take_start ? '0 : accept ? idx_q + 1'b1 : idx_q;
    perr_d = take_start ? 1'b0 : check ? err : perr_q;
    fc_d = (state_q == REPORT && fc_q != '1) ? fc_q + 1'b1 : fc_q;
    ec_d = (state_q == REPORT && perr_q && ec_q != '1) ? ec_q + 1'b1 : ec_q;
  end
  // outputs decoded from state
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == REPORT;
    parity_err = perr_q;
    frame_count = fc_q;
    err_count = ec_q;
  end
endmodule

// File: tb/tb_parity_frame_sequencer.sv
// tb_parity_frame_sequencer: table vectors, corner sequences and random run against a frame-level model
module tb_parity_frame_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic busy_e, done_e, perr_e, busy_o, done_o, perr_o, busy_s, done_s, perr_s;
  logic [7:0] fc_e, ec_e, fc_o, ec_o;
  logic [1:0] fc_s, ec_s;
  always #5 clk = ~clk;

  parity_frame_sequencer #(.DATA_BITS(3), .EVEN_PARITY(1'b1), .CNT_W(8)) u_even (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy_e), .done(done_e), .parity_err(perr_e), .frame_count(fc_e), .err_count(ec_e));
  parity_frame_sequencer #(.DATA_BITS(3), .EVEN_PARITY(1'b0), .CNT_W(8)) u_odd (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy_o), .done(done_o), .parity_err(perr_o), .frame_count(fc_o), .err_count(ec_o));
  parity_frame_sequencer #(.DATA_BITS(3), .EVEN_PARITY(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy_s), .done(done_s), .parity_err(perr_s), .frame_count(fc_s), .err_count(ec_s));

  localparam int DB = 3;
  int applied = 0, miscompares = 0;
  bit in_frame = 0, rep = 0;
  bit frame_bits[$];
  bit mode_even[3] = '{1'b1, 1'b0, 1'b1};
  int maxc[3] = '{255, 255, 3};
  bit m_perr[3];
  int m_fc[3], m_ec[3];
  int done_seen;

  typedef struct {
    logic r, s, v, b;
    logic [18:0] exp;
  } vec_t;
  vec_t tv[19];

  function automatic vec_t mk(logic r, s, v, b, bz, dn, pe, int fc, int ec);
    mk = '{r, s, v, b, {bz, dn, pe, 8'(fc), 8'(ec)}};
  endfunction

  function automatic logic [18:0] actual(int k);
    case (k)
      0: actual = {busy_e, done_e, perr_e, fc_e, ec_e};
      1: actual = {busy_o, done_o, perr_o, fc_o, ec_o};
      default: actual = {busy_s, done_s, perr_s, 6'd0, fc_s, 6'd0, ec_s};
    endcase
  endfunction

  function automatic logic [18:0] model(int k);
    model = {in_frame | rep, rep, m_perr[k], 8'(m_fc[k]), 8'(m_ec[k])};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // frame-level reference: collect bits after start, judge the whole frame once DB+1 bits are in
  task automatic model_update(bit r, bit s, bit v, bit b);
    if (r) begin
      in_frame = 0; rep = 0; frame_bits.delete();
      for (int k = 0; k < 3; k++) begin m_perr[k] = 0; m_fc[k] = 0; m_ec[k] = 0; end
    end else if (rep) begin
      rep = 0;
      for (int k = 0; k < 3; k++) begin
        if (m_fc[k] < maxc[k]) m_fc[k]++;
        if (m_perr[k] && m_ec[k] < maxc[k]) m_ec[k]++;
      end
    end else if (!in_frame) begin
      if (s) begin
        in_frame = 1; frame_bits.delete();
        for (int k = 0; k < 3; k++) m_perr[k] = 0;
      end
    end else if (v) begin
      frame_bits.push_back(b);
      if (frame_bits.size() == DB + 1) begin
        int ones = 0;
        foreach (frame_bits[i]) ones += int'(frame_bits[i]);
        in_frame = 0; rep = 1;
        for (int k = 0; k < 3; k++) m_perr[k] = mode_even[k] ? (ones % 2 == 1) : (ones % 2 == 0);
      end
    end
  endtask

  task automatic step(bit r, bit s, bit v, bit b);
    rst = r; start = s; bit_valid = v; bit_in = b;
    @(posedge clk);
    model_update(r, s, v, b);
    #1;
    chk("model_even", 32'(actual(0)), 32'(model(0)));
    chk("model_odd", 32'(actual(1)), 32'(model(1)));
    chk("model_sat", 32'(actual(2)), 32'(model(2)));
    if (done_e) done_seen++;
  endtask

  task automatic frame(bit b0, bit b1, bit b2, bit p);
    step(0, 1, 0, 0);
    step(0, 0, 1, b0);
    step(0, 0, 1, b1);
    step(0, 0, 1, b2);
    step(0, 0, 1, p);
    step(0, 0, 0, 0);
  endtask

  initial begin
    tv[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[1] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0);
    tv[2] = mk(0, 0, 1, 1, 1, 0, 0, 0, 0);
    tv[3] = mk(0, 0, 1, 0, 1, 0, 0, 0, 0);
    tv[4] = mk(0, 0, 1, 1, 1, 0, 0, 0, 0);
    tv[5] = mk(0, 0, 1, 0, 1, 1, 0, 0, 0);
    tv[6] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[7] = mk(0, 1, 0, 0, 1, 0, 0, 1, 0);
    for (int i = 8; i < 11; i++) tv[i] = mk(0, 0, 1, 1, 1, 0, 0, 1, 0);
    tv[11] = mk(0, 0, 1, 0, 1, 1, 1, 1, 0);
    tv[12] = mk(0, 0, 0, 0, 0, 0, 1, 2, 1);
    tv[13] = mk(0, 1, 0, 0, 1, 0, 0, 2, 1);
    for (int i = 14; i < 17; i++) tv[i] = mk(0, 0, 1, 0, 1, 0, 0, 2, 1);
    tv[17] = mk(0, 0, 1, 0, 1, 1, 0, 2, 1);
    tv[18] = mk(0, 0, 0, 0, 0, 0, 0, 3, 1);
    #1;
    for (int i = 0; i < 19; i++) begin
      step(tv[i].r, tv[i].s, tv[i].v, tv[i].b);
      chk($sformatf("table[%0d]", i), 32'(actual(0)), 32'(tv[i].exp));
    end
    frame(0, 0, 0, 1);
    chk("odd_good_perr", 32'(perr_o), 32'd0);
    frame(0, 0, 0, 0);
    chk("odd_bad_perr", 32'(perr_o), 32'd1);
    step(1, 0, 0, 0);
    done_seen = 0;
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("gap_perr", 32'(perr_e), 32'd0);
    chk("gap_frames", 32'(fc_e), 32'd1);
    chk("gap_done_pulses", 32'(done_seen), 32'd1);
    done_seen = 0;
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    chk("rst_mid_state", 32'({busy_e, fc_e, ec_e}), 32'd0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("rst_no_done", 32'(done_seen), 32'd0);
    frame(1, 0, 1, 0);
    chk("post_rst_frame", 32'({fc_e, perr_e}), 32'({8'd1, 1'b0}));
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) frame(1, 0, 0, 0);
    chk("sat_frames", 32'(fc_s), 32'd3);
    chk("sat_errs", 32'(ec_s), 32'd3);
    chk("nosat_errs", 32'(ec_e), 32'd5);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
